// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline boundary: 2-entry skid buffer with valid/ready handshakes.
// Resolves conditional branches from ALU flags and pulses a PC redirect.
module ex_mem_stage #(
    parameter int WIDTH     = 32,
    parameter int FLAG_SIZE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_result,
    input  logic [FLAG_SIZE-1:0] in_flags,
    input  logic                 in_is_branch,
    input  logic [2:0]           in_br_funct3,
    input  logic [WIDTH-1:0]     in_target,
    input  logic [4:0]           in_rd,
    input  logic                 in_rd_we,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic [4:0]           out_rd,
    output logic                 out_rd_we,
    output logic                 out_br_taken,
    output logic                 redirect_valid,
    output logic [WIDTH-1:0]     redirect_pc
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [4:0]       rd;
        logic             rd_we;
        logic             taken;
    } entry_t;

    logic             of_f, sf_f, cf_f, zf_f;
    logic             cond;
    logic             taken;
    logic             accept;
    logic             pop;
    logic [1:0]       fill;
    entry_t           new_e;

    entry_t           slot0_q, slot0_d;
    entry_t           slot1_q, slot1_d;
    logic [1:0]       count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;

    assign of_f = in_flags[3];
    assign sf_f = in_flags[2];
    assign cf_f = in_flags[1];
    assign zf_f = in_flags[0];

    // Branch condition decode from flags {OF,SF,CF,ZF}
    always_comb begin
        cond = 1'b0;
        case (in_br_funct3)
            3'b000:  cond = zf_f;
            3'b001:  cond = ~zf_f;
            3'b100:  cond = sf_f ^ of_f;
            3'b101:  cond = ~(sf_f ^ of_f);
            3'b110:  cond = cf_f;
            3'b111:  cond = ~cf_f;
            default: cond = 1'b0;
        endcase
    end

    assign taken  = in_is_branch & cond;
    assign accept = in_valid & in_ready_q;
    assign pop    = (count_q != 2'd0) & out_ready;
    assign fill   = count_q - {1'b0, pop};

    assign new_e.result = in_result;
    assign new_e.rd     = in_rd;
    assign new_e.rd_we  = in_rd_we & ~in_is_branch;
    assign new_e.taken  = taken;

    // Next-state: FIFO shift/fill, occupancy, ready and redirect pulse
    always_comb begin
        slot0_d          = slot0_q;
        slot1_d          = slot1_q;
        count_d          = count_q + {1'b0, accept} - {1'b0, pop};
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        if (pop) begin
            slot0_d = slot1_q;
        end
        if (accept) begin
            if (fill == 2'd0) begin
                slot0_d = new_e;
            end else begin
                slot1_d = new_e;
            end
        end
        if (accept && taken) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = in_target;
        end
        if (flush) begin
            count_d          = 2'd0;
            redirect_valid_d = 1'b0;
            redirect_pc_d    = redirect_pc_q;
        end
        in_ready_d = (count_d < 2'd2);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_q          <= '0;
            slot1_q          <= '0;
            count_q          <= 2'd0;
            in_ready_q       <= 1'b1;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            slot0_q          <= slot0_d;
            slot1_q          <= slot1_d;
            count_q          <= count_d;
            in_ready_q       <= in_ready_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = (count_q != 2'd0);
    assign out_result     = slot0_q.result;
    assign out_rd         = slot0_q.rd;
    assign out_rd_we      = slot0_q.rd_we;
    assign out_br_taken   = slot0_q.taken;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule
